// File: rtl/fabric_vc_fifo_if.sv
// fabric_vc_fifo_if: ingress and egress valid/ready payload bundle.
// slave is the buffer side, master is the traffic source/sink side.
interface fabric_vc_fifo_if #(
  parameter int PAYLOAD_WIDTH = 34
);
  logic                     in_valid;
  logic                     in_ready;
  logic [PAYLOAD_WIDTH-1:0] in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [PAYLOAD_WIDTH-1:0] out_data;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/fabric_vc_fifo.sv
// fabric_vc_fifo: per-tag virtual-channel queues merged by a round-robin arbiter.
// Define FABRIC_FIFO_STATS_EN for stat_occupancy / stat_stall_cnt outputs.
module fabric_vc_fifo #(
  parameter  int NUM_VC        = 4,
  parameter  int VC_DEPTH      = 2,
  parameter  int DATA_WIDTH    = 32,
  parameter  int TAG_WIDTH     = 2,
  parameter  int BYPASSABLE    = 0,
  localparam int PAYLOAD_WIDTH = DATA_WIDTH + TAG_WIDTH,
  localparam int VC_SEL_W      = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
  localparam int CNT_W         = (VC_DEPTH > 0) ? $clog2(VC_DEPTH + 1) : 1,
  localparam int CFG_W         = (BYPASSABLE > 1) ? BYPASSABLE : 1
) (
  input logic             clk,
  input logic             rst_n,
  fabric_vc_fifo_if.slave bus,
  input logic [CFG_W-1:0] cfg_data
`ifdef FABRIC_FIFO_STATS_EN
  ,
  output logic [NUM_VC*CNT_W-1:0] stat_occupancy,
  output logic [31:0]             stat_stall_cnt
`endif
);

  if (VC_DEPTH < 1) begin : g_err_depth
    $fatal(1, "COMP_FIFO_DEPTH_ZERO");
  end
  if (NUM_VC < 1 || NUM_VC > 16 || DATA_WIDTH < 1 ||
      !(BYPASSABLE inside {0, 1})) begin : g_err_type
    $fatal(1, "COMP_FIFO_INVALID_TYPE");
  end
  if (TAG_WIDTH < VC_SEL_W) begin : g_err_tag
    $fatal(1, "COMP_VC_TAG_TOO_NARROW");
  end

  localparam int PTR_W = (VC_DEPTH > 1) ? $clog2(VC_DEPTH) : 1;
  localparam int SEL_N = 2 ** VC_SEL_W;

  logic [PAYLOAD_WIDTH-1:0] mem [NUM_VC][VC_DEPTH];
  logic [PTR_W-1:0]         head [NUM_VC];
  logic [PTR_W-1:0]         tail [NUM_VC];
  logic [CNT_W-1:0]         cnt [NUM_VC];

  logic [VC_SEL_W-1:0]  rr_ptr;
  logic [VC_SEL_W-1:0]  locked_vc;
  logic [VC_SEL_W-1:0]  scan_vc;
  logic [VC_SEL_W-1:0]  grant;
  logic [VC_SEL_W-1:0]  rr_next;
  logic                 lock;
  logic                 bypass;
  logic                 q_valid;
  logic                 wr;
  logic                 rd;
  logic [TAG_WIDTH-1:0] tag;
  logic [VC_SEL_W-1:0]  vc_in;
  logic [NUM_VC-1:0]    nempty;
  logic [NUM_VC-1:0]    wr_hit;
  logic [NUM_VC-1:0]    rd_hit;
  logic [SEL_N-1:0]     full;

  function automatic logic [PTR_W-1:0] ptr_inc(
    input logic [PTR_W-1:0] p
  );
    if (VC_DEPTH == 1) return '0;
    return (int'(p) == VC_DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  assign tag    = bus.in_data[PAYLOAD_WIDTH-1 -: TAG_WIDTH];
  assign vc_in  = tag[VC_SEL_W-1:0];
  assign bypass = (BYPASSABLE == 1) && cfg_data[0];

  // Tags beyond NUM_VC read as permanently full, so they are never accepted
  always_comb begin
    full   = '1;
    nempty = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      full[v]   = (cnt[v] == CNT_W'(VC_DEPTH));
      nempty[v] = (cnt[v] != '0);
    end
  end

  // Reverse scan: the last hit is the one closest to rr_ptr
  always_comb begin
    scan_vc = rr_ptr;
    for (int i = NUM_VC - 1; i >= 0; i--) begin
      if (nempty[(int'(rr_ptr) + i) % NUM_VC])
        scan_vc = VC_SEL_W'((int'(rr_ptr) + i) % NUM_VC);
    end
  end

  assign grant   = lock ? locked_vc : scan_vc;
  assign rr_next = (int'(grant) == NUM_VC - 1) ? '0 : grant + 1'b1;
  assign q_valid = |nempty;
  assign wr      = !bypass && bus.in_valid && bus.in_ready;
  assign rd      = !bypass && q_valid && bus.out_ready;

  always_comb begin
    wr_hit = '0;
    rd_hit = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      wr_hit[v] = wr && (vc_in == VC_SEL_W'(v));
      rd_hit[v] = rd && (grant == VC_SEL_W'(v));
    end
  end

  always_comb begin
    if (bypass) begin
      bus.out_valid = bus.in_valid;
      bus.out_data  = bus.in_data;
      bus.in_ready  = bus.out_ready;
    end else begin
      bus.out_valid = q_valid;
      bus.out_data  = q_valid ? mem[grant][head[grant]] : '0;
      bus.in_ready  = !full[vc_in];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int v = 0; v < NUM_VC; v++) begin
        head[v] <= '0;
        tail[v] <= '0;
        cnt[v]  <= '0;
      end
      rr_ptr    <= '0;
      lock      <= 1'b0;
      locked_vc <= '0;
    end else begin
      for (int v = 0; v < NUM_VC; v++) begin
        if (wr_hit[v]) tail[v] <= ptr_inc(tail[v]);
        if (rd_hit[v]) head[v] <= ptr_inc(head[v]);
        unique case (1'b1)
          wr_hit[v] && !rd_hit[v]: cnt[v] <= cnt[v] + 1'b1;
          rd_hit[v] && !wr_hit[v]: cnt[v] <= cnt[v] - 1'b1;
          default: ;
        endcase
      end
      if (rd) begin
        rr_ptr <= rr_next;
        lock   <= 1'b0;
      end else if (!bypass && q_valid) begin
        lock      <= 1'b1;
        locked_vc <= grant;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int v = 0; v < NUM_VC; v++) begin
      if (wr_hit[v]) mem[v][tail[v]] <= bus.in_data;
    end
  end

`ifdef FABRIC_FIFO_STATS_EN
  always_comb begin
    stat_occupancy = '0;
    for (int v = 0; v < NUM_VC; v++)
      stat_occupancy[v*CNT_W +: CNT_W] = cnt[v];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_stall_cnt <= '0;
    end else if (!bypass && bus.in_valid && !bus.in_ready &&
                 stat_stall_cnt != 32'hFFFF_FFFF) begin
      stat_stall_cnt <= stat_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fabric_vc_fifo.sv
// tb_fabric_vc_fifo: randomized and directed traffic against a queue-level
// scoreboard of per-VC FIFOs with round-robin arbitration and grant lock.
module tb_fabric_vc_fifo;
  localparam int NV  = 4;
  localparam int DEP = 2;
  localparam int DW  = 32;
  localparam int TW  = 2;
  localparam int PW  = DW + TW;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [0:0] cfg_data = 1'b0;

  always #5 clk = ~clk;

  fabric_vc_fifo_if #(.PAYLOAD_WIDTH(PW)) bus ();

`ifdef FABRIC_FIFO_STATS_EN
  logic [NV*2-1:0] stat_occupancy;
  logic [31:0]     stat_stall_cnt;
`endif

  fabric_vc_fifo #(
    .NUM_VC    (NV),
    .VC_DEPTH  (DEP),
    .DATA_WIDTH(DW),
    .TAG_WIDTH (TW),
    .BYPASSABLE(1)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .cfg_data(cfg_data)
`ifdef FABRIC_FIFO_STATS_EN
    ,
    .stat_occupancy(stat_occupancy),
    .stat_stall_cnt(stat_stall_cnt)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s: got %0h expected %0h at %0t",
                 name, act, exp, $time);
    end
  endtask

  // Reference: one queue per VC, rr pointer and a held grant
  logic [PW-1:0] mq [NV][$];
  int  served [$];
  int  rr_m, lvc_m, g, vc, stall_m;
  bit  lock_m, any, exp_rdy;

  initial begin
    rr_m = 0; lvc_m = 0; lock_m = 0; stall_m = 0;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int v = 0; v < NV; v++) mq[v].delete();
      rr_m = 0; lock_m = 0; stall_m = 0;
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_out_data", 64'(bus.out_data), 64'd0);
      chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    end else if (cfg_data[0]) begin
      chk("byp_valid", 64'(bus.out_valid), 64'(bus.in_valid));
      chk("byp_data", 64'(bus.out_data), 64'(bus.in_data));
      chk("byp_ready", 64'(bus.in_ready), 64'(bus.out_ready));
    end else begin
      vc = int'(bus.in_data[PW-1 -: TW]);
      exp_rdy = mq[vc].size() < DEP;
`ifdef FABRIC_FIFO_STATS_EN
      chk("stall_cnt", 64'(stat_stall_cnt), 64'(stall_m));
      for (int v = 0; v < NV; v++)
        chk("occupancy", 64'(stat_occupancy[v*2 +: 2]), 64'(mq[v].size()));
`endif
      chk("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
      any = 0;
      for (int v = 0; v < NV; v++) if (mq[v].size() > 0) any = 1;
      chk("out_valid", 64'(bus.out_valid), 64'(any));
      if (any) begin
        if (lock_m) g = lvc_m;
        else begin
          g = -1;
          for (int i = 0; i < NV; i++)
            if (g < 0 && mq[(rr_m + i) % NV].size() > 0) g = (rr_m + i) % NV;
        end
        chk("out_data", 64'(bus.out_data), 64'(mq[g][0]));
        if (bus.out_ready) begin
          void'(mq[g].pop_front());
          served.push_back(g);
          rr_m = (g + 1) % NV;
          lock_m = 0;
        end else begin
          lock_m = 1;
          lvc_m = g;
        end
      end
      if (bus.in_valid && exp_rdy) mq[vc].push_back(bus.in_data);
      if (bus.in_valid && !exp_rdy) stall_m++;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(bit v, int t, logic [31:0] d, bit ordy);
    logic [1:0] t2;
    t2 = t[1:0];
    bus.in_valid  = v;
    bus.in_data   = {t2, d};
    bus.out_ready = ordy;
    cyc();
  endtask

  task automatic idle(int n);
    repeat (n) drive(1'b0, 0, 32'h0, 1'b1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;
    repeat (3) cyc();
    rst_n = 1'b1;

    // single-VC latency
    served.delete();
    drive(1'b1, 2, 32'hA5, 1'b1);
    idle(3);
    chk("lat_served_n", 64'(served.size()), 64'd1);
    if (served.size() > 0) chk("lat_vc", 64'(served[0]), 64'd2);

    // head-of-line isolation
    served.delete();
    drive(1'b1, 1, 32'h11, 1'b0);
    drive(1'b1, 1, 32'h12, 1'b0);
    drive(1'b1, 1, 32'h13, 1'b0);
    drive(1'b1, 3, 32'h31, 1'b0);
    idle(8);
    chk("hol_served_n", 64'(served.size()), 64'd3);

    // round robin
    do_reset();
    served.delete();
    drive(1'b1, 0, 32'h01, 1'b0);
    drive(1'b1, 0, 32'h02, 1'b0);
    drive(1'b1, 1, 32'h11, 1'b0);
    drive(1'b1, 1, 32'h12, 1'b0);
    drive(1'b1, 3, 32'h31, 1'b0);
    drive(1'b1, 3, 32'h32, 1'b0);
    idle(10);
    chk("rr_served_n", 64'(served.size()), 64'd6);
    for (int i = 0; i < 6 && i < served.size(); i++)
      chk("rr_order", 64'(served[i]), 64'((i % 3 == 2) ? 3 : i % 3));

    // grant lock
    do_reset();
    served.delete();
    drive(1'b1, 2, 32'h22, 1'b0);
    repeat (3) drive(1'b1, 0, 32'h0C, 1'b0);
    idle(6);
    chk("lock_served_n", 64'(served.size()), 64'd3);
    if (served.size() > 1) begin
      chk("lock_first", 64'(served[0]), 64'd2);
      chk("lock_second", 64'(served[1]), 64'd0);
    end

    // full queue with simultaneous read
    drive(1'b1, 0, 32'hF0, 1'b0);
    drive(1'b1, 0, 32'hF1, 1'b0);
    drive(1'b1, 0, 32'hF2, 1'b1);
    drive(1'b1, 0, 32'hF3, 1'b1);
    idle(6);

    // bypass
    cfg_data = 1'b1;
    drive(1'b1, 0, 32'h3C, 1'b1);
    drive(1'b1, 2, 32'h3C, 1'b0);
    drive(1'b0, 1, 32'h55, 1'b1);
    cfg_data = 1'b0;
    idle(2);

    // stall counting on a full VC
    do_reset();
    drive(1'b1, 1, 32'hB0, 1'b0);
    drive(1'b1, 1, 32'hB1, 1'b0);
    repeat (5) drive(1'b1, 1, 32'hB2, 1'b0);
    drive(1'b0, 1, 32'h0, 1'b0);
    chk("stall_model", 64'(stall_m), 64'd5);
    idle(6);

    // random traffic with a mid-run reset
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      drive(1'($urandom_range(0, 99) < 60), int'($urandom_range(0, NV - 1)),
            $urandom, 1'($urandom_range(0, 99) < 55));
    end
    idle(12);
    for (int v = 0; v < NV; v++)
      chk("drained", 64'(mq[v].size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fabric_vc_fifo.md
# fabric_vc_fifo

Multi-channel pipeline buffer for fabric links that carry tagged traffic. Each of NUM_VC virtual channels gets its own circular queue, so a stalled channel does not block the others. Writes are routed by the low tag bits. A round-robin arbiter merges the non-empty queues onto one valid/ready output. It sits on tagged fabric edges wherever per-tag head-of-line blocking must be broken, and has an optional configuration-selected combinational bypass.

## Interface
Parameters:
- NUM_VC, 4: number of virtual channels; legal range 1..16.
- VC_DEPTH, 2: entries per channel; must be >= 1.
- DATA_WIDTH, 32: payload data bits; must be > 0.
- TAG_WIDTH, 2: tag bits; must be >= max(1, $clog2(NUM_VC)).
- BYPASSABLE, 0: 1 adds a one-bit bypass configuration.
- Derived: PAYLOAD_WIDTH = DATA_WIDTH + TAG_WIDTH; VC_SEL_W = max(1, $clog2(NUM_VC)); CNT_W = $clog2(VC_DEPTH + 1).
- Elaboration fatal errors: COMP_FIFO_DEPTH_ZERO, COMP_FIFO_INVALID_TYPE, COMP_VC_TAG_TOO_NARROW.

Ports:
- clk, input, 1: clock.
- rst_n, input, 1: reset; asynchronous, active-low.
- in_valid, input, 1: input payload valid.
- in_ready, output, 1: input accept.
- in_data, input, PAYLOAD_WIDTH: tag occupies the MSBs; vc_in = tag[VC_SEL_W-1:0].
- out_valid, output, 1: output payload valid.
- out_ready, input, 1: downstream accept.
- out_data, output, PAYLOAD_WIDTH: payload, with tag unchanged.
- cfg_data, input, max(1, BYPASSABLE): bit0 = bypass_en; ignored when BYPASSABLE = 0.

## Operation
- Storage: NUM_VC independent circular buffers of VC_DEPTH entries, each with its own head, tail and count.
- vc_in >= NUM_VC is possible when NUM_VC is not a power of 2. Such a beat is a protocol error: in_ready = 0 for that beat and nothing is written.
- in_ready = !full[vc_in]. It depends combinationally on in_data, so the sender must hold in_data stable while in_valid is high.
- Write: in_valid && in_ready stores the beat into queue vc_in.
- Arbiter: rr_ptr (VC_SEL_W bits) marks the highest-priority VC.
  - grant = first non-empty VC scanning rr_ptr, rr_ptr+1, … modulo NUM_VC.
  - out_valid = any queue non-empty; out_data = head entry of queue grant.
- Grant lock: while out_valid && !out_ready, grant is held at its current VC (register locked_vc plus a lock flag) even if other VCs fill. Data therefore stays stable until the handshake.
- On handshake from VC k: pop queue k, set rr_ptr to (k+1) mod NUM_VC, clear the lock.
- Same cycle, same VC, write and read:
  - Allowed when the queue is not full; count is unchanged.
  - When the queue is full, in_ready is already 0, so there is no write-through.
- Empty queue: there is no read-through; a written beat is first visible the next cycle.
- Bypass (BYPASSABLE && bypass_en):
  - out_valid = in_valid, in_ready = out_ready, out_data = in_data.
  - The queues see no writes or reads, and their contents are retained.
  - Changing bypass_en while queues hold data is illegal configuration; behaviour is undefined, with no X on outputs.

## Timing
- Reset, asynchronous: all heads, tails and counts = 0, rr_ptr = 0, lock = 0.
  - Outputs: out_valid = 0, out_data = 0, in_ready = 1 when not bypassed.
- Reset asserted mid-transfer discards all queued beats immediately.
- Latency: write at cycle N, out_valid at cycle N+1 at the earliest, when the queue was empty and won arbitration.
- Throughput: 1 beat/cycle in and 1 beat/cycle out sustained, including reads from different VCs on consecutive cycles.
- Pointers wrap from VC_DEPTH-1 to 0; for VC_DEPTH = 1 the pointers are constant 0.
- Count arithmetic is CNT_W wide and never overflows, because full blocks the write.

## Configuration
- Macro FABRIC_FIFO_STATS_EN. When defined, two extra output ports exist:
  - stat_occupancy, NUM_VC*CNT_W bits: per-VC counts, with VC0 in the LSBs.
  - stat_stall_cnt, 32 bits: counts cycles with in_valid && !in_ready. It saturates at 0xFFFFFFFF, resets to 0, and does not count in bypass.
- When undefined, neither port exists and there is no associated logic; datapath behaviour is identical.

## Test plan
- Single VC latency: NUM_VC=4, VC_DEPTH=2, out_ready=1; write tag=2 data=0xA5 at cycle 0 -> out_valid at cycle 1 with out_data tag 2 / data 0xA5; all queues empty at cycle 2.
- Head-of-line isolation: out_ready=0; fill VC1 with 2 beats -> in_ready=0 for tag 1 and 1 for tag 3; a tag-3 write is accepted.
- Round-robin: preload VC0, VC1 and VC3 with 2 beats each, then out_ready=1 -> output VC order 0,1,3,0,1,3.
- Grant lock: VC2 valid with out_ready=0 for 3 cycles while VC0 is written -> out_data held at the VC2 beat until the handshake; VC0 is output next.
- Full simultaneous access: VC0 full, with in_valid tag0 and out_ready=1 -> no write that cycle and count 2→1; a write the next cycle is accepted.
- Bypass and stats: BYPASSABLE=1, bypass_en=1 -> same-cycle pass-through of 0x3C. With FABRIC_FIFO_STATS_EN, stalling 5 cycles on a full VC gives stat_stall_cnt=5.
